axis_governor: RTL and testbench
================================

AXIS_GOVERNOR -- requirements
Module: axis_governor

Interface
REQ-001 The block SHALL have parameters (name, default, meaning): DATA_WIDTH, 32, stream data width (>=16).
REQ-002 ID_WIDTH, 12, width of the command ID field.
REQ-003 GOV_ID, 0, command ID this instance answers to.
REQ-004 CNT_WIDTH, 16, width of the flit counters (<=16).
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 Ports (name, direction, width, meaning): clk, in, 1, clock.
REQ-007 rst, in, 1, synchronous active-low reset.
REQ-008 din_TDATA/TVALID/TLAST in, din_TREADY out, DATA_WIDTH/1/1/1, upstream AXIS.
REQ-009 dout_TDATA/TVALID/TLAST out, dout_TREADY in, DATA_WIDTH/1/1/1, downstream AXIS.
REQ-010 log_TDATA/TVALID/TLAST out, log_TREADY in, DATA_WIDTH/1/1/1, copy stream.
REQ-011 cmd_in_TDATA in 32, cmd_in_TVALID in 1, cmd_out_TDATA out 32, cmd_out_TVALID out 1, daisy-chained command bus with no backpressure.

Function
REQ-012 Command word SHALL be {id[31:20], addr[19:16], val[15:0]}; only the low ID_WIDTH bits of id SHALL be compared, and a match is id==GOV_ID.
REQ-013 Non-matching commands SHALL appear unchanged on cmd_out exactly 1 cycle later.
REQ-014 Matching commands SHALL be consumed (cmd_out_TVALID=0 next cycle), except READ.
REQ-015 addr 0 MODE: val[2:0] selects 0 PASS, 1 PAUSE, 2 DROP, 3 STEP, 4 LOG; values 5-7 SHALL be ignored.
REQ-016 addr 1 STEP_N: load step counter with val.
REQ-017 addr 2 INJ_DATA: inject register = val zero-extended to DATA_WIDTH.
REQ-018 addr 3 INJ_FIRE: set inject-pending with TLAST=val[0]; ignored if already pending.
REQ-019 addr 4 READ: cmd_out next cycle = {id, 4'h4, counter}, where val[0]=0 selects pass_cnt and val[0]=1 selects drop_cnt; TVALID=1 for one cycle.
REQ-020 addr 5 CLR: zero both counters; other addr values are consumed with no effect.
REQ-021 A MODE/STEP_N write SHALL take effect on the cycle after the command cycle, including mid-packet.
REQ-022 PASS: dout=din combinationally, din_TREADY=dout_TREADY.
REQ-023 PAUSE: din_TREADY=0, dout_TVALID=0.
REQ-024 DROP: din_TREADY=1, dout_TVALID=0; each din flit increments drop_cnt.
REQ-025 STEP: behaves as PASS while step counter>0; each dout flit decrements it.
REQ-026 STEP: when step counter is 0, the mode SHALL switch to PAUSE on the following cycle.
REQ-027 STEP entered with step counter 0 SHALL go to PAUSE with no flit passed.
REQ-028 LOG: dout_TVALID = log_TVALID = din_TVALID & dout_TREADY & log_TREADY, and din_TREADY = dout_TREADY & log_TREADY.
REQ-029 LOG: a flit SHALL be transferred to dout and log in the same cycle or not at all.
REQ-030 Outside LOG mode, log_TVALID SHALL be 0.
REQ-031 A packet-open flag SHALL set on a din flit with TLAST=0 and clear on a din flit with TLAST=1.
REQ-032 Injection SHALL start only when pending and packet-open=0, in any mode except PAUSE.
REQ-033 While injecting: din_TREADY=0, and dout presents {inj_data, inj_last, TVALID=1} held stable until dout_TREADY, then pending clears.
REQ-034 Injected flits SHALL NOT be counted.
REQ-035 pass_cnt SHALL count din->dout flits; both counters SHALL saturate at all-ones.
REQ-036 A CLR in the same cycle as an increment SHALL leave the counter at 0.

Reset
REQ-037 While rst=0: din_TREADY=0, dout_TVALID=0, log_TVALID=0, cmd_out_TVALID=0, overriding combinational paths.
REQ-038 On reset: mode=PASS, step=0, counters=0, inject-pending=0, packet-open=0, inj_data=0.
REQ-039 Reset mid-packet or mid-injection SHALL abandon the flit with no completion.

Verification
REQ-040 PASS, dout_TREADY=1, 3 flits (A,B,C, TLAST on C) -> same on dout, zero latency; READ val=0 -> cmd_out=0x00040003 one cycle later.
REQ-041 STEP_N=2 then MODE=3 with 5 flits offered -> exactly 2 flits pass, then din_TREADY=0 and mode reads as PAUSE.
REQ-042 INJ_DATA=0xBEEF, INJ_FIRE val=1 mid-packet -> inject is deferred until din TLAST, then dout=0x0000BEEF with TLAST=1 and din_TREADY=0 during it.
REQ-043 LOG with log_TREADY=0 -> din_TREADY=0 and no dout flit; raising log_TREADY gives identical flits on dout and log.
REQ-044 Command id=5 with GOV_ID=0 -> forwarded unchanged on cmd_out after 1 cycle; DROP mode with 0xFFFF+2 flits -> drop_cnt=0xFFFF.
REQ-045 rst=0 during injection -> all TVALID/TREADY outputs 0 in that cycle; after release, PASS mode with no pending inject.

Source files
------------

// File: rtl/axis_governor.sv
// AXI-Stream governor: passes, pauses, drops, single-steps or logs a stream
// under control of a daisy-chained 32-bit command bus. It can also inject a
// single flit between packets, and it keeps saturating pass/drop flit counters.
module axis_governor #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 12,
    parameter int GOV_ID     = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din_TDATA,
    input  logic                  din_TVALID,
    input  logic                  din_TLAST,
    output logic                  din_TREADY,
    output logic [DATA_WIDTH-1:0] dout_TDATA,
    output logic                  dout_TVALID,
    output logic                  dout_TLAST,
    input  logic                  dout_TREADY,
    output logic [DATA_WIDTH-1:0] log_TDATA,
    output logic                  log_TVALID,
    output logic                  log_TLAST,
    input  logic                  log_TREADY,
    input  logic [31:0]           cmd_in_TDATA,
    input  logic                  cmd_in_TVALID,
    output logic [31:0]           cmd_out_TDATA,
    output logic                  cmd_out_TVALID
);

    typedef enum logic [2:0] {
        MODE_PASS  = 3'd0,
        MODE_PAUSE = 3'd1,
        MODE_DROP  = 3'd2,
        MODE_STEP  = 3'd3,
        MODE_LOG   = 3'd4
    } mode_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    mode_e                 mode_q, mode_d;
    logic [CNT_WIDTH-1:0]  step_q, step_d;
    logic [CNT_WIDTH-1:0]  pass_q, pass_d;
    logic [CNT_WIDTH-1:0]  drop_q, drop_d;
    logic                  inj_pend_q, inj_pend_d;
    logic                  inj_last_q, inj_last_d;
    logic                  inj_busy_q, inj_busy_d;
    logic [DATA_WIDTH-1:0] inj_data_q, inj_data_d;
    logic                  pkt_open_q, pkt_open_d;
    logic [31:0]           cmd_out_q, cmd_out_d;
    logic                  cmd_out_v_q, cmd_out_v_d;

    logic [ID_WIDTH-1:0]   cmd_id_s;
    logic [3:0]            cmd_addr_s;
    logic [15:0]           cmd_val_s;
    logic                  cmd_hit_s;
    logic                  injecting_s;
    logic                  din_fire_s;
    logic                  pass_fire_s;
    logic                  drop_fire_s;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == CNT_MAX) ? c : c + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign cmd_id_s   = cmd_in_TDATA[20 +: ID_WIDTH];
    assign cmd_addr_s = cmd_in_TDATA[19:16];
    assign cmd_val_s  = cmd_in_TDATA[15:0];
    assign cmd_hit_s  = cmd_in_TVALID && (cmd_id_s == ID_WIDTH'(GOV_ID));

    // Once an injected flit is on dout it stays there until accepted, even if
    // the mode changes to PAUSE underneath it.
    assign injecting_s = inj_pend_q &&
                         (inj_busy_q || (!pkt_open_q && (mode_q != MODE_PAUSE)));

    // A din transfer that also produced a dout flit is a pass; otherwise a drop.
    assign din_fire_s  = din_TVALID && din_TREADY;
    assign pass_fire_s = din_fire_s && dout_TVALID;
    assign drop_fire_s = din_fire_s && !dout_TVALID;

    assign log_TDATA      = din_TDATA;
    assign log_TLAST      = din_TLAST;
    assign cmd_out_TDATA  = cmd_out_q;
    assign cmd_out_TVALID = rst && cmd_out_v_q;

    // Stream routing per mode; reset and injection override the mode.
    always_comb begin
        din_TREADY  = 1'b0;
        dout_TVALID = 1'b0;
        dout_TDATA  = din_TDATA;
        dout_TLAST  = din_TLAST;
        log_TVALID  = 1'b0;
        if (!rst) begin
            din_TREADY  = 1'b0;
            dout_TVALID = 1'b0;
        end else if (injecting_s) begin
            dout_TVALID = 1'b1;
            dout_TDATA  = inj_data_q;
            dout_TLAST  = inj_last_q;
        end else begin
            case (mode_q)
                MODE_PASS: begin
                    din_TREADY  = dout_TREADY;
                    dout_TVALID = din_TVALID;
                end
                MODE_DROP: begin
                    din_TREADY  = 1'b1;
                end
                MODE_STEP: begin
                    din_TREADY  = (step_q != '0) && dout_TREADY;
                    dout_TVALID = (step_q != '0) && din_TVALID;
                end
                MODE_LOG: begin
                    din_TREADY  = dout_TREADY && log_TREADY;
                    dout_TVALID = din_TVALID && dout_TREADY && log_TREADY;
                    log_TVALID  = din_TVALID && dout_TREADY && log_TREADY;
                end
                default: begin
                    din_TREADY  = 1'b0;
                    dout_TVALID = 1'b0;
                end
            endcase
        end
    end

    // Next-state: stream side effects first, then command writes, which win.
    always_comb begin
        pkt_open_d  = din_fire_s ? !din_TLAST : pkt_open_q;
        pass_d      = pass_fire_s ? sat_inc(pass_q) : pass_q;
        drop_d      = drop_fire_s ? sat_inc(drop_q) : drop_q;
        step_d      = (pass_fire_s && (mode_q == MODE_STEP)) ?
                      step_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1} : step_q;
        mode_d      = ((mode_q == MODE_STEP) && (step_q == '0)) ? MODE_PAUSE : mode_q;
        inj_pend_d  = (injecting_s && dout_TREADY) ? 1'b0 : inj_pend_q;
        inj_busy_d  = injecting_s && !dout_TREADY;
        inj_last_d  = inj_last_q;
        inj_data_d  = inj_data_q;
        cmd_out_d   = cmd_in_TDATA;
        cmd_out_v_d = cmd_in_TVALID && !cmd_hit_s;
        if (cmd_hit_s) begin
            case (cmd_addr_s)
                4'd0: begin
                    if (cmd_val_s[2:0] <= 3'd4) begin
                        mode_d = mode_e'(cmd_val_s[2:0]);
                    end else begin
                        mode_d = mode_d;
                    end
                end
                4'd1: step_d = cmd_val_s[CNT_WIDTH-1:0];
                4'd2: begin
                    if (!injecting_s) begin
                        inj_data_d = DATA_WIDTH'(cmd_val_s);
                    end else begin
                        inj_data_d = inj_data_q;
                    end
                end
                4'd3: begin
                    if (!inj_pend_q) begin
                        inj_pend_d = 1'b1;
                        inj_last_d = cmd_val_s[0];
                    end else begin
                        inj_last_d = inj_last_q;
                    end
                end
                4'd4: begin
                    cmd_out_v_d = 1'b1;
                    cmd_out_d   = {cmd_in_TDATA[31:20], 4'h4,
                                   cmd_val_s[0] ? 16'(drop_q) : 16'(pass_q)};
                end
                4'd5: begin
                    pass_d = '0;
                    drop_d = '0;
                end
                default: cmd_out_v_d = 1'b0;
            endcase
        end else begin
            cmd_out_d = cmd_in_TDATA;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q      <= MODE_PASS;
            step_q      <= '0;
            pass_q      <= '0;
            drop_q      <= '0;
            inj_pend_q  <= 1'b0;
            inj_last_q  <= 1'b0;
            inj_busy_q  <= 1'b0;
            inj_data_q  <= '0;
            pkt_open_q  <= 1'b0;
            cmd_out_q   <= 32'h0;
            cmd_out_v_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            step_q      <= step_d;
            pass_q      <= pass_d;
            drop_q      <= drop_d;
            inj_pend_q  <= inj_pend_d;
            inj_last_q  <= inj_last_d;
            inj_busy_q  <= inj_busy_d;
            inj_data_q  <= inj_data_d;
            pkt_open_q  <= pkt_open_d;
            cmd_out_q   <= cmd_out_d;
            cmd_out_v_q <= cmd_out_v_d;
        end
    end

endmodule

// File: tb/tb_axis_governor.sv
// Directed bench for axis_governor: a per-cycle vector table followed by
// hand-written sequences for stepping, injection, reset and saturation.
module tb_axis_governor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din_TDATA;
    logic        din_TVALID, din_TLAST, din_TREADY;
    logic [31:0] dout_TDATA;
    logic        dout_TVALID, dout_TLAST, dout_TREADY;
    logic [31:0] log_TDATA;
    logic        log_TVALID, log_TLAST, log_TREADY;
    logic [31:0] cmd_in_TDATA, cmd_out_TDATA;
    logic        cmd_in_TVALID, cmd_out_TVALID;

    int n_chk = 0;
    int n_fail = 0;

    axis_governor dut (
        .clk(clk), .rst(rst),
        .din_TDATA(din_TDATA), .din_TVALID(din_TVALID), .din_TLAST(din_TLAST), .din_TREADY(din_TREADY),
        .dout_TDATA(dout_TDATA), .dout_TVALID(dout_TVALID), .dout_TLAST(dout_TLAST), .dout_TREADY(dout_TREADY),
        .log_TDATA(log_TDATA), .log_TVALID(log_TVALID), .log_TLAST(log_TLAST), .log_TREADY(log_TREADY),
        .cmd_in_TDATA(cmd_in_TDATA), .cmd_in_TVALID(cmd_in_TVALID),
        .cmd_out_TDATA(cmd_out_TDATA), .cmd_out_TVALID(cmd_out_TVALID)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] d;
        logic        dv, dl, dr, lr, cv;
        logic [31:0] cd;
        logic        e_dinr, e_dv;
        logic [31:0] e_dd;
        logic        e_dl, e_lv, e_cv;
        logic [31:0] e_cd;
    } vec_t;

    function automatic logic [31:0] cmd(input logic [11:0] id, input logic [3:0] a, input logic [15:0] v);
        return {id, a, v};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge; return mid-cycle.
    task automatic drive(input logic r, input logic [31:0] d, input logic dv, input logic dl,
                         input logic dr, input logic lr, input logic cv, input logic [31:0] cd);
        @(posedge clk);
        #1;
        rst = r; din_TDATA = d; din_TVALID = dv; din_TLAST = dl;
        dout_TREADY = dr; log_TREADY = lr; cmd_in_TVALID = cv; cmd_in_TDATA = cd;
        #3;
    endtask

    task automatic send_cmd(input logic [3:0] a, input logic [15:0] v);
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, cmd(12'h000, a, v));
    endtask

    task automatic idle();
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        drive(v.rst, v.d, v.dv, v.dl, v.dr, v.lr, v.cv, v.cd);
        chk($sformatf("v%0d din_TREADY", idx), {31'h0, din_TREADY}, {31'h0, v.e_dinr});
        chk($sformatf("v%0d dout_TVALID", idx), {31'h0, dout_TVALID}, {31'h0, v.e_dv});
        chk($sformatf("v%0d log_TVALID", idx), {31'h0, log_TVALID}, {31'h0, v.e_lv});
        chk($sformatf("v%0d cmd_out_TVALID", idx), {31'h0, cmd_out_TVALID}, {31'h0, v.e_cv});
        if (v.e_dv) begin
            chk($sformatf("v%0d dout_TDATA", idx), dout_TDATA, v.e_dd);
            chk($sformatf("v%0d dout_TLAST", idx), {31'h0, dout_TLAST}, {31'h0, v.e_dl});
        end
        if (v.e_lv) begin
            chk($sformatf("v%0d log_TDATA", idx), log_TDATA, v.e_dd);
            chk($sformatf("v%0d log_TLAST", idx), {31'h0, log_TLAST}, {31'h0, v.e_dl});
        end
        if (v.e_cv) begin
            chk($sformatf("v%0d cmd_out_TDATA", idx), cmd_out_TDATA, v.e_cd);
        end
    endtask

    initial begin
        vec_t vt[22];
        int   hs;
        logic [31:0] fwd;
        fwd = cmd(12'h005, 4'h0, 16'h1234);

        rst = 1'b0; din_TDATA = 32'h0; din_TVALID = 1'b0; din_TLAST = 1'b0;
        dout_TREADY = 1'b0; log_TREADY = 1'b0; cmd_in_TVALID = 1'b0; cmd_in_TDATA = 32'h0;

        //         rst d             dv dl dr lr cv cd                       dinr dv dd          dl lv cv cd
        vt[0]  = '{1'b0, 32'h0,      1, 0, 1, 1, 1, cmd(12'h0, 4'h4, 16'h0), 0, 0, 32'h0,        0, 0, 0, 32'h0};
        vt[1]  = '{1'b1, 32'h0,      0, 0, 1, 1, 0, 32'h0,                   1, 0, 32'h0,        0, 0, 0, 32'h0};
        vt[2]  = '{1'b1, 32'hAAAA0001, 1, 0, 1, 1, 0, 32'h0,                 1, 1, 32'hAAAA0001, 0, 0, 0, 32'h0};
        vt[3]  = '{1'b1, 32'hBBBB0002, 1, 0, 1, 1, 0, 32'h0,                 1, 1, 32'hBBBB0002, 0, 0, 0, 32'h0};
        vt[4]  = '{1'b1, 32'hCCCC0003, 1, 1, 1, 1, 0, 32'h0,                 1, 1, 32'hCCCC0003, 1, 0, 0, 32'h0};
        vt[5]  = '{1'b1, 32'h0,      0, 0, 1, 1, 1, cmd(12'h0, 4'h4, 16'h0), 1, 0, 32'h0,        0, 0, 0, 32'h0};
        vt[6]  = '{1'b1, 32'h0,      0, 0, 1, 1, 1, fwd,                     1, 0, 32'h0,        0, 0, 1, 32'h00040003};
        vt[7]  = '{1'b1, 32'h0,      0, 0, 1, 1, 1, cmd(12'h0, 4'h0, 16'h1), 1, 0, 32'h0,        0, 0, 1, fwd};
        vt[8]  = '{1'b1, 32'hD0,     1, 1, 1, 1, 1, cmd(12'h0, 4'h0, 16'h5), 0, 0, 32'h0,        0, 0, 0, 32'h0};
        vt[9]  = '{1'b1, 32'hD0,     1, 1, 1, 1, 1, cmd(12'h0, 4'h0, 16'h2), 0, 0, 32'h0,        0, 0, 0, 32'h0};
        vt[10] = '{1'b1, 32'hD1,     1, 1, 0, 1, 0, 32'h0,                   1, 0, 32'h0,        0, 0, 0, 32'h0};
        vt[11] = '{1'b1, 32'hD2,     1, 1, 0, 1, 1, cmd(12'h0, 4'h4, 16'h1), 1, 0, 32'h0,        0, 0, 0, 32'h0};
        vt[12] = '{1'b1, 32'h0,      0, 0, 1, 1, 1, cmd(12'h0, 4'h5, 16'h0), 1, 0, 32'h0,        0, 0, 1, 32'h00040001};
        vt[13] = '{1'b1, 32'h0,      0, 0, 1, 1, 1, cmd(12'h0, 4'h4, 16'h1), 1, 0, 32'h0,        0, 0, 0, 32'h0};
        vt[14] = '{1'b1, 32'hD3,     1, 1, 1, 1, 1, cmd(12'h0, 4'h5, 16'h0), 1, 0, 32'h0,        0, 0, 1, 32'h00040000};
        vt[15] = '{1'b1, 32'h0,      0, 0, 1, 1, 1, cmd(12'h0, 4'h4, 16'h1), 1, 0, 32'h0,        0, 0, 0, 32'h0};
        vt[16] = '{1'b1, 32'h0,      0, 0, 1, 1, 1, cmd(12'h0, 4'h0, 16'h4), 1, 0, 32'h0,        0, 0, 1, 32'h00040000};
        vt[17] = '{1'b1, 32'h1111AAAA, 1, 1, 1, 0, 0, 32'h0,                 0, 0, 32'h0,        0, 0, 0, 32'h0};
        vt[18] = '{1'b1, 32'h1111AAAA, 1, 1, 1, 1, 0, 32'h0,                 1, 1, 32'h1111AAAA, 1, 1, 0, 32'h0};
        vt[19] = '{1'b1, 32'h2222BBBB, 1, 0, 0, 1, 1, cmd(12'h0, 4'h0, 16'h0), 0, 0, 32'h0,      0, 0, 0, 32'h0};
        vt[20] = '{1'b1, 32'h2222BBBB, 1, 0, 0, 1, 1, cmd(12'h0, 4'h4, 16'h0), 0, 1, 32'h2222BBBB, 0, 0, 0, 32'h0};
        vt[21] = '{1'b1, 32'h0,      0, 0, 1, 1, 0, 32'h0,                   1, 0, 32'h0,        0, 0, 1, 32'h00040001};

        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 22; i++) apply_vec(vt[i], i);

        // STEP_N=2 then STEP: exactly two flits pass, then the mode is PAUSE.
        send_cmd(4'h1, 16'd2);
        send_cmd(4'h0, 16'd3);
        hs = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h5000 + i, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            if (din_TREADY && din_TVALID) hs++;
        end
        chk("step_pass_count", hs, 2);
        chk("step_din_ready_after", {31'h0, din_TREADY}, 32'h0);
        drive(1'b1, 32'h5100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, cmd(12'h0, 4'h1, 16'd3));
        hs = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h5200 + i, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            if (din_TREADY) hs++;
        end
        chk("step_mode_is_pause", hs, 0);
        // STEP entered with a zero step count passes nothing.
        send_cmd(4'h1, 16'd0);
        send_cmd(4'h0, 16'd3);
        hs = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h5300 + i, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            if (din_TREADY || dout_TVALID) hs++;
        end
        chk("step_zero_no_flit", hs, 0);

        // Injection deferred while a packet is open.
        send_cmd(4'h0, 16'd0);
        send_cmd(4'h2, 16'hBEEF);
        drive(1'b1, 32'h6001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        send_cmd(4'h3, 16'h0001);
        drive(1'b1, 32'h6002, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("inj_defer_data_p2", dout_TDATA, 32'h6002);
        chk("inj_defer_ready_p2", {31'h0, din_TREADY}, 32'h1);
        drive(1'b1, 32'h6003, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("inj_defer_data_p3", dout_TDATA, 32'h6003);
        drive(1'b1, 32'h6004, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("inj_ready_low", {31'h0, din_TREADY}, 32'h0);
        chk("inj_valid", {31'h0, dout_TVALID}, 32'h1);
        chk("inj_data", dout_TDATA, 32'h0000BEEF);
        chk("inj_last", {31'h0, dout_TLAST}, 32'h1);
        drive(1'b1, 32'h6004, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("inj_data_held", dout_TDATA, 32'h0000BEEF);
        chk("inj_ready_held_low", {31'h0, din_TREADY}, 32'h0);
        drive(1'b1, 32'h6004, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("inj_done_data", dout_TDATA, 32'h6004);
        chk("inj_done_ready", {31'h0, din_TREADY}, 32'h1);
        drive(1'b1, 32'h6005, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        send_cmd(4'h4, 16'h0);
        idle();
        chk("inj_not_counted_v", {31'h0, cmd_out_TVALID}, 32'h1);
        chk("inj_not_counted", cmd_out_TDATA, 32'h00040008);

        // Reset in the middle of an injection, in DROP mode.
        send_cmd(4'h0, 16'd2);
        send_cmd(4'h3, 16'h0000);
        drive(1'b1, 32'h7001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, fwd);
        chk("rinj_valid", {31'h0, dout_TVALID}, 32'h1);
        chk("rinj_data", dout_TDATA, 32'h0000BEEF);
        drive(1'b0, 32'h7001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("rst_din_ready", {31'h0, din_TREADY}, 32'h0);
        chk("rst_dout_valid", {31'h0, dout_TVALID}, 32'h0);
        chk("rst_log_valid", {31'h0, log_TVALID}, 32'h0);
        chk("rst_cmd_valid", {31'h0, cmd_out_TVALID}, 32'h0);
        drive(1'b1, 32'h7002, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("post_rst_pass_valid", {31'h0, dout_TVALID}, 32'h1);
        chk("post_rst_pass_data", dout_TDATA, 32'h7002);
        chk("post_rst_ready", {31'h0, din_TREADY}, 32'h1);

        // Drop counter saturates at all-ones.
        send_cmd(4'h0, 16'd2);
        for (int i = 0; i < 32'h10001; i++) begin
            drive(1'b1, i, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        end
        send_cmd(4'h4, 16'h1);
        idle();
        chk("drop_sat_v", {31'h0, cmd_out_TVALID}, 32'h1);
        chk("drop_sat", cmd_out_TDATA, 32'h0004FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
